// File: rtl/proc_pkg.sv
// Shared opcode constants and controller state encoding for the simple processor core.
package proc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        IMM,
        MOVE,
        LOADA,
        CALC,
        WB
    } state_e;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: add/sub with carry-out (borrow on SUB), bitwise logic ops.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] g,
    output logic              cout
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            // The extra MSB of the subtraction is set exactly when a < b (borrow).
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
        g    = wide[DATA_W-1:0];
        cout = wide[DATA_W];
    end

endmodule

// File: rtl/simple_proc_core.sv
// Multi-cycle register-file processor core: fetch/immediate/move/ALU sequencing with debug readout.
//   state | meaning
//   FETCH | idle, accept next instruction word
//   IMM   | wait for immediate word of LDI, write Rx
//   MOVE  | Rx <= Ry
//   LOADA | A <= Rx
//   CALC  | G <= A op Ry, update carry on ADD/SUB
//   WB    | Rx <= G
module simple_proc_core
    import proc_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 8,
    localparam int RW     = $clog2(NREG),
    localparam int IW     = 3 + 2 * RW,
    localparam int WW     = (IW > DATA_W) ? IW : DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WW-1:0]     in_word,
    output logic              in_ready,
    output logic              done,
    output logic              carry,
    output logic              zero,
    input  logic [RW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [RW-1:0]     rx_q, rx_d, ry_q, ry_d;
    logic [DATA_W-1:0] a_q, a_d, g_q, g_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              carry_q, carry_d, zero_q, zero_d, done_q, done_d;
    logic              run_q;
    logic [DATA_W-1:0] dbg_q, dbg_d;

    logic              accept, we;
    logic [DATA_W-1:0] wdata, alu_g;
    logic              alu_cout;

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .a    (a_q),
        .b    (regs_q[ry_q]),
        .op   (op_q),
        .g    (alu_g),
        .cout (alu_cout)
    );

    // run_q holds in_ready low until the first edge after reset is released.
    assign in_ready = run_q && ((state_q == FETCH) || (state_q == IMM));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        a_d     = a_q;
        g_d     = g_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        regs_d  = regs_q;
        we      = 1'b0;
        wdata   = '0;
        case (state_q)
            FETCH: begin
                if (accept) begin
                    op_d = in_word[IW-1 -: 3];
                    rx_d = in_word[2*RW-1 -: RW];
                    ry_d = in_word[RW-1:0];
                    case (in_word[IW-1 -: 3])
                        OP_NOP:  done_d  = 1'b1;
                        OP_LDI:  state_d = IMM;
                        OP_MOV:  state_d = MOVE;
                        default: state_d = LOADA;
                    endcase
                end
            end
            IMM: begin
                if (accept) begin
                    we      = 1'b1;
                    wdata   = in_word[DATA_W-1:0];
                    state_d = FETCH;
                end
            end
            MOVE: begin
                we      = 1'b1;
                wdata   = regs_q[ry_q];
                state_d = FETCH;
            end
            LOADA: begin
                a_d     = regs_q[rx_q];
                state_d = CALC;
            end
            CALC: begin
                g_d = alu_g;
                if (is_arith(op_q)) carry_d = alu_cout;
                state_d = WB;
            end
            WB: begin
                we      = 1'b1;
                wdata   = g_q;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (we) begin
            regs_d[rx_q] = wdata;
            zero_d       = (wdata == '0);
            done_d       = 1'b1;
        end
        // Forward the write so dbg_data shows the new value in the done cycle.
        dbg_d = (we && (rx_q == dbg_sel)) ? wdata : regs_q[dbg_sel];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            op_q    <= OP_NOP;
            rx_q    <= '0;
            ry_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
            dbg_q   <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            a_q     <= a_d;
            g_q     <= g_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            run_q   <= 1'b1;
            dbg_q   <= dbg_d;
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign done     = done_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign dbg_data = dbg_q;

endmodule
